block_xfer_seq: RTL and testbench
=================================

BLOCK_XFER_SEQ -- requirements
Module: block_xfer_seq

Interface
REQ-001 SHALL have parameter ACK_TIMEOUT, default 0, meaning cycles to wait for mem_ack before abort (0 = never abort).
REQ-002 SHALL have clk  in  1  single clock; all state changes on posedge clk.
REQ-003 SHALL have rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have start  in  1  one-cycle request to begin an LDM/STM; ignored unless idle.
REQ-005 SHALL have is_load  in  1  1 = LDM (memory to registers), 0 = STM.
REQ-006 SHALL have up, pre, writeback  in  1 each  ARM U, P, W bits, sampled with start.
REQ-007 SHALL have base_reg  in  4  base register number; base_val  in  32  base register value.
REQ-008 SHALL have reg_list  in  16  register list; bit i selects register i.
REQ-009 SHALL have mem_req, mem_we  out  1 each; mem_addr, mem_wdata  out  32; mem_ack  in  1; mem_rdata  in  32  word memory port.
REQ-010 SHALL have rd_sel  out  4, wr_data  out  32, latch_reg  out  1  register-bank write port.
REQ-011 SHALL have rs_sel  out  4, rs_data  in  32  register-bank combinational read port for STM.
REQ-012 SHALL have busy  out  1, done  out  1 (one-cycle pulse), abort  out  1 (one-cycle pulse).

Function
REQ-013 SHALL latch is_load/up/pre/writeback/base_reg/base_val/reg_list on start while in IDLE.
REQ-014 SHALL compute N = popcount(reg_list), 0..16, in 5 bits.
REQ-015 SHALL set the first address: IA = base; IB = base+4; DA = base-4N+4; DB = base-4N (32-bit modulo arithmetic, wrap permitted).
REQ-016 SHALL transfer registers in ascending number order at ascending word addresses, incrementing mem_addr by 4 per transfer.
REQ-017 SHALL use states IDLE, REQ, GAP, WB, DONE: IDLE-start->REQ (or DONE if N=0); REQ-mem_ack->GAP; GAP->REQ if registers remain, else WB if writeback, else DONE; WB->DONE; DONE->IDLE.
REQ-018 SHALL assert mem_req in REQ only, holding mem_addr/mem_we/mem_wdata stable until mem_ack; first mem_req is the cycle after start.
REQ-019 SHALL drive mem_we = !is_load; for STM rs_sel = current register and mem_wdata = rs_data.
REQ-020 SHALL, for LDM, pulse latch_reg in GAP with rd_sel = current register and wr_data = mem_rdata registered on the ack cycle.
REQ-021 SHALL, in WB, pulse latch_reg with rd_sel = base_reg, wr_data = base ± 4N (+ if up).
REQ-022 SHALL suppress WB when is_load and reg_list[base_reg] = 1 (loaded value wins).
REQ-023 SHALL, for N = 0, perform no memory access and no writeback; done pulses 2 cycles after start.
REQ-024 SHALL hold busy = 1 from the cycle after an accepted start until the done cycle, inclusive.
REQ-025 SHALL, when ACK_TIMEOUT > 0 and mem_req waits ACK_TIMEOUT cycles, drop mem_req, pulse abort, skip WB, return to IDLE.
REQ-026 SHALL never assert latch_reg and mem_req in the same cycle.

Reset
REQ-027 SHALL, on rst, enter IDLE and drive mem_req, mem_we, latch_reg, busy, done, abort = 0 and mem_addr, mem_wdata, wr_data, rd_sel, rs_sel = 0.
REQ-028 SHALL, on rst mid-transfer, abandon the operation with no further latch_reg or writeback; rst overrides start.

Structure
REQ-029 SHALL place state encoding and the addressing-mode constants (IA/IB/DA/DB) in a shared package with the core's other decode constants.
REQ-030 SHALL use one sub-module, lowest_set_bit, returning the index (4 bits) and valid of the lowest set bit of a 16-bit mask; the sequencer clears each bit after its transfer.

Verification
REQ-031 SHALL cover LDMIA base=0x100, list=0x000B, W=1, ack every cycle -> reads 0x100/0x104/0x108 into r0/r1/r3, then rd_sel=base_reg with wr_data=0x10C, done.
REQ-032 SHALL cover STMDB base_reg=13, base_val=0x200, list=0x4010 -> writes r4 at 0x1F8, r14 at 0x1FC, writeback r13=0x1F8.
REQ-033 SHALL cover LDMIA with base in list (base_reg=2, list=0x0004) -> one load into r2, no writeback pulse.
REQ-034 SHALL cover list=0x0000 -> no mem_req, no latch_reg, done 2 cycles after start.
REQ-035 SHALL cover mem_ack delayed 3 cycles per word, start pulsed while busy, and rst asserted mid-transfer -> addresses held stable, second start ignored, all outputs 0 after reset with no further latch_reg.
REQ-036 SHALL cover ACK_TIMEOUT=4 with mem_ack never asserted -> abort pulse after 4 cycles, no latch_reg, return to IDLE.

Source files
------------

// File: rtl/block_xfer_seq_pkg.sv
// Shared decode constants for the LDM/STM block transfer sequencer.
// Holds sequencer states, addressing modes and address helpers.
package block_xfer_seq_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_REQ  = 3'd1;
  localparam logic [2:0] ST_GAP  = 3'd2;
  localparam logic [2:0] ST_WB   = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  // Addressing mode, indexed by {P, U}
  localparam logic [1:0] AM_DA = 2'b00;
  localparam logic [1:0] AM_IA = 2'b01;
  localparam logic [1:0] AM_DB = 2'b10;
  localparam logic [1:0] AM_IB = 2'b11;

  typedef struct packed {
    logic        ld;
    logic        wb_en;
    logic [3:0]  base;
    logic [31:0] wb_val;
  } op_t;

  function automatic logic [4:0] popcount16(
    input logic [15:0] m
  );
    logic [4:0] c;
    c = 5'd0;
    for (int i = 0; i < 16; i++)
      c = c + {4'd0, m[i]};
    return c;
  endfunction

  function automatic logic [31:0] span4(
    input logic [4:0] n
  );
    return {25'd0, n, 2'b00};
  endfunction

  function automatic logic [31:0] first_addr(
    input logic [1:0]  mode,
    input logic [31:0] base,
    input logic [4:0]  n
  );
    logic [31:0] a;
    case (mode)
      AM_IA:   a = base;
      AM_IB:   a = base + 32'd4;
      AM_DA:   a = base - span4(n) + 32'd4;
      default: a = base - span4(n);
    endcase
    return a;
  endfunction

endpackage

// File: rtl/block_xfer_seq_lowest_set_bit.sv
// Priority encoder: index of the lowest set bit in a 16-bit mask.
// valid is low when the mask is empty (idx is then 0).
module lowest_set_bit
  import block_xfer_seq_pkg::*;
(
  input  logic [15:0] mask,
  output logic [3:0]  idx,
  output logic        valid
);

  // scan from the top so the lowest set bit wins
  always_comb begin
    idx   = 4'd0;
    valid = |mask;
    for (int i = 15; i >= 0; i--)
      if (mask[i]) idx = 4'(i);
  end

endmodule

// File: rtl/block_xfer_seq.sv
// LDM/STM block transfer sequencer: walks a register list over a
// word memory port, then optionally writes the base register back.
module block_xfer_seq
  import block_xfer_seq_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_load,
  input  logic        up,
  input  logic        pre,
  input  logic        writeback,
  input  logic [3:0]  base_reg,
  input  logic [31:0] base_val,
  input  logic [15:0] reg_list,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [3:0]  rd_sel,
  output logic [31:0] wr_data,
  output logic        latch_reg,
  output logic [3:0]  rs_sel,
  input  logic [31:0] rs_data,
  output logic        busy,
  output logic        done,
  output logic        abort
);

  logic [2:0]  state;
  op_t         op;
  logic [15:0] mask;
  logic [31:0] addr;
  logic [31:0] rdata_q;
  logic [31:0] wait_cnt;
  logic [3:0]  cur_idx;
  logic        cur_valid;
  logic [15:0] rest;
  logic [4:0]  n_new;
  logic        timeout;

  lowest_set_bit u_lsb (
    .mask  (mask),
    .idx   (cur_idx),
    .valid (cur_valid)
  );

  assign rest    = mask & ~(16'h0001 << cur_idx);
  assign n_new   = popcount16(reg_list);
  assign timeout = (ACK_TIMEOUT != 32'd0) &&
                   (wait_cnt == ACK_TIMEOUT - 32'd1);

  // sequencer state, latched operation and pulse outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      op       <= '0;
      mask     <= '0;
      addr     <= '0;
      rdata_q  <= '0;
      wait_cnt <= '0;
      done     <= 1'b0;
      abort    <= 1'b0;
    end else begin
      done  <= (state == ST_DONE);
      abort <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            op.ld     <= is_load;
            op.wb_en  <= writeback &
                         ~(is_load & reg_list[base_reg]);
            op.base   <= base_reg;
            op.wb_val <= up ? base_val + span4(n_new)
                            : base_val - span4(n_new);
            mask      <= reg_list;
            addr      <= first_addr({pre, up}, base_val, n_new);
            wait_cnt  <= '0;
            state     <= (n_new == 5'd0) ? ST_DONE : ST_REQ;
          end
        end
        ST_REQ: begin
          if (mem_ack) begin
            rdata_q <= mem_rdata;
            state   <= ST_GAP;
          end else if (timeout) begin
            abort <= 1'b1;
            state <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end
        ST_GAP: begin
          mask     <= rest;
          wait_cnt <= '0;
          if (rest != 16'd0) begin
            addr  <= addr + 32'd4;
            state <= ST_REQ;
          end else if (op.wb_en) begin
            state <= ST_WB;
          end else begin
            state <= ST_DONE;
          end
        end
        ST_WB:   state <= ST_DONE;
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // memory and register-bank port decode from the current state
  always_comb begin
    mem_req   = (state == ST_REQ) && cur_valid;
    mem_we    = mem_req && !op.ld;
    mem_addr  = addr;
    mem_wdata = mem_we ? rs_data : 32'd0;
    rs_sel    = cur_idx;
    latch_reg = 1'b0;
    rd_sel    = 4'd0;
    wr_data   = 32'd0;
    if (state == ST_WB) begin
      latch_reg = 1'b1;
      rd_sel    = op.base;
      wr_data   = op.wb_val;
    end else if (state == ST_GAP && op.ld) begin
      latch_reg = 1'b1;
      rd_sel    = cur_idx;
      wr_data   = rdata_q;
    end
    busy = (state != ST_IDLE) || done;
  end

endmodule

// File: tb/tb_block_xfer_seq.sv
// Directed and randomized bench for block_xfer_seq against a
// transaction-level model of the LDM/STM address and data rules.
module tb_block_xfer_seq;

  typedef struct {
    logic [31:0] a;
    logic        we;
    logic [31:0] d;
  } acc_t;

  typedef struct {
    logic [3:0]  rd;
    logic [31:0] d;
  } lat_t;

  logic        clk = 1'b0;
  logic        rst, start, start_to;
  logic        is_load, up, pre, writeback;
  logic [3:0]  base_reg;
  logic [31:0] base_val;
  logic [15:0] reg_list;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  rd_sel, rs_sel;
  logic [31:0] wr_data, rs_data;
  logic        latch_reg, busy, done, abort;

  logic        to_mem_req, to_mem_we, to_latch_reg;
  logic [31:0] to_mem_addr, to_mem_wdata, to_wr_data;
  logic [3:0]  to_rd_sel, to_rs_sel;
  logic        to_busy, to_done, to_abort;
  logic        to_ack = 1'b0;
  logic [31:0] zero32 = 32'd0;

  logic [31:0] regs [16];
  logic [31:0] seed;
  acc_t        acc_q[$];
  lat_t        lat_q[$];

  int checks = 0;
  int failures = 0;
  int ack_delay = 0;
  int wait_n = 0;
  int busy_cnt = 0, done_cnt = 0, abort_cnt = 0;
  int ovl_err = 0, stab_err = 0;
  int to_req_cnt = 0, to_abort_cnt = 0, to_latch_cnt = 0;
  logic [64:0] held = '0;
  logic        req_prev = 1'b0;

  always #5 clk = ~clk;

  assign rs_data = regs[rs_sel];

  block_xfer_seq dut (
    .clk(clk), .rst(rst), .start(start),
    .is_load(is_load), .up(up), .pre(pre),
    .writeback(writeback), .base_reg(base_reg),
    .base_val(base_val), .reg_list(reg_list),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .rd_sel(rd_sel), .wr_data(wr_data),
    .latch_reg(latch_reg), .rs_sel(rs_sel),
    .rs_data(rs_data), .busy(busy), .done(done),
    .abort(abort)
  );

  block_xfer_seq #(.ACK_TIMEOUT(4)) dut_to (
    .clk(clk), .rst(rst), .start(start_to),
    .is_load(is_load), .up(up), .pre(pre),
    .writeback(writeback), .base_reg(base_reg),
    .base_val(base_val), .reg_list(reg_list),
    .mem_req(to_mem_req), .mem_we(to_mem_we),
    .mem_addr(to_mem_addr), .mem_wdata(to_mem_wdata),
    .mem_ack(to_ack), .mem_rdata(zero32),
    .rd_sel(to_rd_sel), .wr_data(to_wr_data),
    .latch_reg(to_latch_reg), .rs_sel(to_rs_sel),
    .rs_data(zero32), .busy(to_busy), .done(to_done),
    .abort(to_abort)
  );

  function automatic logic [31:0] memval(
    input logic [31:0] a
  );
    return (a * 32'h9E37_79B1) ^ seed;
  endfunction

  function automatic void chk(
    input string tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endfunction

  // memory responder: ack after ack_delay waiting cycles
  always @(negedge clk) begin
    if (mem_req && !mem_ack && wait_n >= ack_delay) begin
      mem_ack   <= 1'b1;
      mem_rdata <= memval(mem_addr);
      wait_n    <= 0;
      acc_q.push_back('{mem_addr, mem_we, mem_wdata});
    end else begin
      mem_ack   <= 1'b0;
      mem_rdata <= 32'hDEAD_BEEF;
      wait_n    <= (mem_req && !mem_ack) ? wait_n + 1 : 0;
    end
  end

  // register bank and event monitors
  always @(negedge clk) begin
    if (latch_reg) begin
      lat_q.push_back('{rd_sel, wr_data});
      regs[rd_sel] <= wr_data;
    end
    if (latch_reg && mem_req) ovl_err <= ovl_err + 1;
    if (mem_req && req_prev &&
        {mem_addr, mem_we, mem_wdata} !== held)
      stab_err <= stab_err + 1;
    held     <= {mem_addr, mem_we, mem_wdata};
    req_prev <= mem_req;
    if (busy)  busy_cnt  <= busy_cnt + 1;
    if (done)  done_cnt  <= done_cnt + 1;
    if (abort) abort_cnt <= abort_cnt + 1;
    if (to_mem_req)   to_req_cnt   <= to_req_cnt + 1;
    if (to_abort)     to_abort_cnt <= to_abort_cnt + 1;
    if (to_latch_reg) to_latch_cnt <= to_latch_cnt + 1;
  end

  task automatic run_op(
    input string nm,
    input logic ld, input logic u,
    input logic p, input logic w,
    input logic [3:0] br, input logic [31:0] bv,
    input logic [15:0] lst,
    input int dly, input int spur
  );
    acc_t ea[$];
    lat_t el[$];
    logic [31:0] lo, a;
    int n, k, exp_t, done_at, d0, b0;
    bit wb;
    @(negedge clk);
    n = $countones(lst);
    if (p) lo = u ? bv + 32'd4 : bv - 32'(4 * n);
    else   lo = u ? bv : bv - 32'(4 * n) + 32'd4;
    k = 0;
    for (int i = 0; i < 16; i++) begin
      if (lst[i]) begin
        a = lo + 32'(4 * k);
        k++;
        ea.push_back('{a, !ld, regs[i]});
        if (ld) el.push_back('{4'(i), memval(a)});
      end
    end
    wb = w && (n != 0) && !(ld && lst[br]);
    if (wb)
      el.push_back('{br, u ? bv + 32'(4 * n)
                           : bv - 32'(4 * n)});
    exp_t = (n == 0) ? 2
          : n * (dly + 2) + (wb ? 1 : 0) + 2;
    acc_q.delete();
    lat_q.delete();
    d0 = done_cnt;
    b0 = busy_cnt;
    ack_delay = dly;
    is_load = ld; up = u; pre = p; writeback = w;
    base_reg = br; base_val = bv; reg_list = lst;
    start = 1'b1;
    done_at = 0;
    for (int c = 1; c <= 500 && done_at == 0; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (spur > 1 && c == spur) begin
        start = 1'b1;
        is_load = !ld;
        reg_list = 16'hFFFF;
      end
      if (spur > 1 && c == spur + 1) start = 1'b0;
      if (done) done_at = c;
    end
    @(negedge clk);
    chk({nm, ".done_at"}, 64'(done_at), 64'(exp_t));
    chk({nm, ".done_n"}, 64'(done_cnt - d0), 64'd1);
    chk({nm, ".busy"}, 64'(busy_cnt - b0), 64'(exp_t));
    chk({nm, ".n_acc"}, 64'(acc_q.size()),
        64'(ea.size()));
    for (int i = 0; i < ea.size() && i < acc_q.size(); i++) begin
      chk($sformatf("%s.addr%0d", nm, i),
          64'(acc_q[i].a), 64'(ea[i].a));
      chk($sformatf("%s.we%0d", nm, i),
          64'(acc_q[i].we), 64'(ea[i].we));
      if (!ld)
        chk($sformatf("%s.wdata%0d", nm, i),
            64'(acc_q[i].d), 64'(ea[i].d));
    end
    chk({nm, ".n_lat"}, 64'(lat_q.size()),
        64'(el.size()));
    for (int i = 0; i < el.size() && i < lat_q.size(); i++) begin
      chk($sformatf("%s.rd%0d", nm, i),
          64'(lat_q[i].rd), 64'(el[i].rd));
      chk($sformatf("%s.wr%0d", nm, i),
          64'(lat_q[i].d), 64'(el[i].d));
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, ".ctl"},
        64'({mem_req, mem_we, latch_reg, busy, done, abort}),
        64'd0);
    chk({nm, ".addr"}, 64'(mem_addr), 64'd0);
    chk({nm, ".wdata"}, 64'(mem_wdata), 64'd0);
    chk({nm, ".wr_data"}, 64'(wr_data), 64'd0);
    chk({nm, ".sel"}, 64'({rd_sel, rs_sel}), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int l0, d0, b0, r0, a0, t0l, ab_at;
    logic [15:0] lst;
    rst = 1'b1; start = 1'b0; start_to = 1'b0;
    is_load = 1'b0; up = 1'b0; pre = 1'b0;
    writeback = 1'b0; base_reg = '0;
    base_val = '0; reg_list = '0;
    seed = 32'h1234_5678;
    for (int r = 0; r < 16; r++)
      regs[r] <= 32'h1000_0000 + 32'(r);
    repeat (3) @(negedge clk);
    chk_zero("reset");
    chk("reset.to",
        64'({to_mem_req, to_mem_we, to_latch_reg, to_busy,
             to_done, to_abort, to_rd_sel, to_rs_sel,
             to_mem_addr, to_mem_wdata}), 64'd0);
    chk("reset.to_wr", 64'(to_wr_data), 64'd0);
    rst = 1'b0;

    run_op("ldmia", 1, 1, 0, 1, 4'd5, 32'h100,
           16'h000B, 0, 0);
    if (lat_q.size() == 4) begin
      chk("ldmia.wb_rd", 64'(lat_q[3].rd), 64'd5);
      chk("ldmia.wb_val", 64'(lat_q[3].d), 64'h10C);
    end

    regs[4]  <= 32'h4444_0004;
    regs[14] <= 32'hEEEE_000E;
    run_op("stmdb", 0, 0, 1, 1, 4'd13, 32'h200,
           16'h4010, 0, 0);
    if (acc_q.size() == 2) begin
      chk("stmdb.a0", 64'(acc_q[0].a), 64'h1F8);
      chk("stmdb.d1", 64'(acc_q[1].d), 64'hEEEE_000E);
    end

    run_op("base_in_list", 1, 1, 0, 1, 4'd2, 32'h80,
           16'h0004, 0, 0);
    run_op("empty_ld", 1, 1, 0, 1, 4'd3, 32'h40,
           16'h0000, 0, 0);
    run_op("empty_st", 0, 0, 1, 1, 4'd3, 32'h40,
           16'h0000, 1, 0);
    run_op("stmda", 0, 0, 0, 1, 4'd0, 32'h0000_0008,
           16'h8101, 1, 0);

    // slow acks plus a start pulse while busy
    run_op("slow_spur", 1, 1, 1, 1, 4'd7, 32'h300,
           16'h0606, 3, 2);
    d0 = done_cnt;
    repeat (8) @(negedge clk);
    chk("spur.no_acc", 64'(acc_q.size()), 64'd4);
    chk("spur.no_done", 64'(done_cnt - d0), 64'd0);
    chk("spur.idle", 64'(busy), 64'd0);

    // reset in the middle of a slow load
    @(negedge clk);
    acc_q.delete();
    lat_q.delete();
    ack_delay = 3;
    is_load = 1; up = 1; pre = 0; writeback = 1;
    base_reg = 4'd1; base_val = 32'h400;
    reg_list = 16'h00F0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("midrst.lat_before", 64'(lat_q.size()), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk_zero("midrst");
    rst = 1'b0;
    d0 = done_cnt;
    repeat (20) @(negedge clk);
    chk("midrst.no_lat", 64'(lat_q.size()), 64'd1);
    chk("midrst.no_done", 64'(done_cnt - d0), 64'd0);

    // reset wins over a simultaneous start
    b0 = busy_cnt;
    rst = 1'b1;
    start = 1'b1;
    reg_list = 16'h0001;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    acc_q.delete();
    repeat (6) @(negedge clk);
    chk("rst_start.no_acc", 64'(acc_q.size()), 64'd0);
    chk("rst_start.no_busy", 64'(busy_cnt - b0), 64'd0);

    // ack timeout on the second instance
    @(negedge clk);
    r0 = to_req_cnt;
    a0 = to_abort_cnt;
    t0l = to_latch_cnt;
    is_load = 1; up = 1; pre = 0; writeback = 1;
    base_reg = 4'd1; base_val = 32'h500;
    reg_list = 16'h0003;
    start_to = 1'b1;
    ab_at = 0;
    for (int c = 1; c <= 30 && ab_at == 0; c++) begin
      @(negedge clk);
      if (c == 1) start_to = 1'b0;
      if (to_abort) ab_at = c;
    end
    chk("to.abort_at", 64'(ab_at), 64'd5);
    chk("to.busy", 64'(to_busy), 64'd0);
    @(negedge clk);
    chk("to.req_cycles", 64'(to_req_cnt - r0), 64'd4);
    chk("to.aborts", 64'(to_abort_cnt - a0), 64'd1);
    chk("to.no_lat", 64'(to_latch_cnt - t0l), 64'd0);
    chk("to.idle", 64'({to_mem_req, to_abort}), 64'd0);
    reg_list = 16'h0000;
    start_to = 1'b1;
    @(negedge clk);
    start_to = 1'b0;
    @(negedge clk);
    chk("to.restart_done", 64'(to_done), 64'd1);

    // randomized operations
    for (int t = 0; t < 40; t++) begin
      seed = $urandom();
      for (int r = 0; r < 16; r++)
        regs[r] <= $urandom();
      lst = ($urandom_range(0, 7) == 0) ? 16'h0
                                         : 16'($urandom());
      run_op($sformatf("rnd%0d", t),
             1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)),
             4'($urandom_range(0, 15)),
             $urandom(), lst,
             $urandom_range(0, 2), 0);
    end

    l0 = ovl_err;
    chk("no_overlap", 64'(l0), 64'd0);
    chk("addr_stable", 64'(stab_err), 64'd0);
    chk("no_abort_main", 64'(abort_cnt), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
